// File: rtl/lee_rtc_pkg.sv
// Shared definitions for the RTC reader: FSM states, RTC register addresses,
// bus slot phase boundaries and the {CS, AD, RD, WR} strobe encodings.
package lee_rtc_pkg;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        CICLO   = 2'd1,
        PUBLICA = 2'd2
    } estado_t;

    localparam int unsigned NUM_REGS = 6;

    // RTC register addresses, in sweep order
    localparam logic [7:0] DIR_SEGUNDOS = 8'h21;
    localparam logic [7:0] DIR_MINUTOS  = 8'h22;
    localparam logic [7:0] DIR_HORAS    = 8'h23;
    localparam logic [7:0] DIR_DIA      = 8'h24;
    localparam logic [7:0] DIR_MES      = 8'h25;
    localparam logic [7:0] DIR_ANIO     = 8'h26;

    // Last cycle of each phase within a 40-cycle bus slot
    localparam logic [5:0] FIN_REPOSO  = 6'd3;
    localparam logic [5:0] FIN_DIR     = 6'd5;
    localparam logic [5:0] FIN_ESCR    = 6'd11;
    localparam logic [5:0] FIN_CIERRE  = 6'd13;
    localparam logic [5:0] FIN_ESPERA  = 6'd25;
    localparam logic [5:0] FIN_LECT    = 6'd31;
    localparam logic [5:0] FIN_SLOT    = 6'd39;

    // Strobe patterns {CS, AD, RD, WR}, all active-low
    localparam logic [3:0] CTRL_INACTIVO = 4'b1111;
    localparam logic [3:0] CTRL_DIR      = 4'b1011;
    localparam logic [3:0] CTRL_ESCR     = 4'b0010;
    localparam logic [3:0] CTRL_LECT     = 4'b0101;

    function automatic logic [7:0] direccion(input logic [2:0] idx);
        logic [7:0] d;
        case (idx)
            3'd0:    d = DIR_SEGUNDOS;
            3'd1:    d = DIR_MINUTOS;
            3'd2:    d = DIR_HORAS;
            3'd3:    d = DIR_DIA;
            3'd4:    d = DIR_MES;
            default: d = DIR_ANIO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lee_rtc_temporizador_bus.sv
// Bus slot timer: 40-cycle slot counter plus phase decode.
// Ports: clk, reset (async, active-high), activo (slot running),
//        control ({CS,AD,RD,WR} strobes), conduce (drive address on bus),
//        captura (sample ad_in this cycle), fin_slot (last cycle of slot).
module temporizador_bus
    import lee_rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       activo,
    output logic [3:0] control,
    output logic       conduce,
    output logic       captura,
    output logic       fin_slot
);

    logic [5:0] cnt;

    // Counter is held at 0 whenever no slot runs, so every slot starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!activo || cnt == FIN_SLOT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        control  = CTRL_INACTIVO;
        conduce  = 1'b0;
        captura  = 1'b0;
        fin_slot = 1'b0;
        if (activo) begin
            if (cnt <= FIN_REPOSO) begin
                control = CTRL_INACTIVO;
            end else if (cnt <= FIN_DIR) begin
                control = CTRL_DIR;
                conduce = 1'b1;
            end else if (cnt <= FIN_ESCR) begin
                control = CTRL_ESCR;
                conduce = 1'b1;
            end else if (cnt <= FIN_CIERRE) begin
                control = CTRL_DIR;
                conduce = 1'b1;
            end else if (cnt <= FIN_ESPERA) begin
                control = CTRL_INACTIVO;
            end else if (cnt <= FIN_LECT) begin
                // RD low: bus released, RTC drives it
                control = CTRL_LECT;
            end else begin
                control = CTRL_INACTIVO;
            end
            captura  = (cnt == FIN_LECT);
            fin_slot = (cnt == FIN_SLOT);
        end
    end

endmodule

// File: rtl/lee_rtc.sv
// RTC reader: sweeps registers 21h..26h over the multiplexed AD bus, one
// 40-cycle slot each, then publishes all six BCD values at once.
// Ports: clk, reset (async, active-high), habilita (start/continue sweeps),
//        ad_in/ad_out/ad_oe (AD bus), control ({CS,AD,RD,WR} active-low),
//        segundos..anio (last complete snapshot), dato_valido (publish pulse).
module lee_rtc
    import lee_rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       habilita,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic [3:0] control,
    output logic [7:0] segundos,
    output logic [7:0] minutos,
    output logic [7:0] horas,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic       dato_valido
);

    estado_t    estado, estado_sig;
    logic [2:0] idx;
    logic [7:0] sombra [0:NUM_REGS-1];
    logic       conduce, captura, fin_slot;

    temporizador_bus u_temporizador (
        .clk      (clk),
        .reset    (reset),
        .activo   (estado == CICLO),
        .control  (control),
        .conduce  (conduce),
        .captura  (captura),
        .fin_slot (fin_slot)
    );

    always_comb begin
        estado_sig = estado;
        case (estado)
            ESPERA:  if (habilita) estado_sig = CICLO;
            CICLO: begin
                // habilita is only honoured at slot boundaries
                if (fin_slot) begin
                    if (!habilita)
                        estado_sig = ESPERA;
                    else if (idx == 3'(NUM_REGS - 1))
                        estado_sig = PUBLICA;
                end
            end
            PUBLICA: estado_sig = habilita ? CICLO : ESPERA;
            default: estado_sig = ESPERA;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= ESPERA;
            idx    <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) sombra[i] <= '0;
            segundos <= '0;
            minutos  <= '0;
            horas    <= '0;
            dia      <= '0;
            mes      <= '0;
            anio     <= '0;
        end else begin
            estado <= estado_sig;

            if (estado_sig != CICLO)
                idx <= '0;
            else if (estado == CICLO && fin_slot)
                idx <= idx + 1'b1;

            // An aborted sweep is thrown away rather than left half-filled.
            if (estado == CICLO && estado_sig == ESPERA) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) sombra[i] <= '0;
            end else if (captura) begin
                sombra[idx] <= ad_in;
            end

            // Loaded on entry to PUBLICA so the values are already stable
            // during the dato_valido cycle.
            if (estado == CICLO && estado_sig == PUBLICA) begin
                segundos <= sombra[0];
                minutos  <= sombra[1];
                horas    <= sombra[2];
                dia      <= sombra[3];
                mes      <= sombra[4];
                anio     <= sombra[5];
            end
        end
    end

    assign dato_valido = (estado == PUBLICA);
    assign ad_oe       = conduce;
    assign ad_out      = conduce ? direccion(idx) : '0;

endmodule

// File: tb/tb_lee_rtc.sv
`timescale 1ns/1ps
module tb_lee_rtc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       habilita = 1'b0;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [3:0] control;
    logic [7:0] segundos, minutos, horas, dia, mes, anio;
    logic       dato_valido;

    always #5 clk = ~clk;

    lee_rtc dut (
        .clk         (clk),
        .reset       (reset),
        .habilita    (habilita),
        .ad_in       (ad_in),
        .ad_out      (ad_out),
        .ad_oe       (ad_oe),
        .control     (control),
        .segundos    (segundos),
        .minutos     (minutos),
        .horas       (horas),
        .dia         (dia),
        .mes         (mes),
        .anio        (anio),
        .dato_valido (dato_valido)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s[3:0] != 4'd9) return s + 8'd1;
        if (s[7:4] == 4'd5) return 8'h00;
        return {s[7:4] + 4'd1, 4'h0};
    endfunction

    // ---------------- RTC chip model on the bus side ----------------
    logic [7:0] mem [0:5] = '{default: 8'h00};
    logic [7:0] bus_addr = 8'h00;
    bit         auto_inc = 1'b0;

    always @(negedge clk) if (ad_oe) bus_addr = ad_out;

    always_comb begin
        int k;
        k = int'(bus_addr) - 'h21;
        ad_in = 8'hFF;
        if (control == 4'b0101 && k >= 0 && k < 6) ad_in = mem[k];
    end

    // ---------------- reference model ----------------
    // t = -1 idle, 0..239 position within the six-slot sweep, 240 publish.
    int         t = -1;
    logic [7:0] cap [0:5] = '{default: 8'h00};
    logic [7:0] exp_out [0:5] = '{default: 8'h00};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t = -1;
            cap = '{default: 8'h00};
            exp_out = '{default: 8'h00};
        end else if (t < 0 || t == 240) begin
            t = habilita ? 0 : -1;
        end else begin
            if (t % 40 == 31) cap[t / 40] = mem[t / 40];
            if (t % 40 == 39 && !habilita) begin
                t = -1;
            end else begin
                t = t + 1;
                if (t == 240) exp_out = cap;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [3:0] ec;
        logic       eoe;
        logic [7:0] eout;
        logic       edv;
        int         c;
        ec = 4'hF; eoe = 1'b0; eout = 8'h00; edv = (t == 240);
        if (t >= 0 && t < 240) begin
            c = t % 40;
            if (c >= 4 && c <= 5)        begin ec = 4'b1011; eoe = 1'b1; end
            else if (c >= 6 && c <= 11)  begin ec = 4'b0010; eoe = 1'b1; end
            else if (c >= 12 && c <= 13) begin ec = 4'b1011; eoe = 1'b1; end
            else if (c >= 26 && c <= 31) ec = 4'b0101;
            if (eoe) eout = 8'(32'h21 + t / 40);
        end
        checks++;
        if ({control, ad_oe, ad_out, dato_valido} !== {ec, eoe, eout, edv}) begin
            failures++;
            $display("FAIL bus t=%0d: got ctrl=%b oe=%b out=%h dv=%b want ctrl=%b oe=%b out=%h dv=%b",
                     t, control, ad_oe, ad_out, dato_valido, ec, eoe, eout, edv);
        end
        checks++;
        if ({segundos, minutos, horas, dia, mes, anio} !==
            {exp_out[0], exp_out[1], exp_out[2], exp_out[3], exp_out[4], exp_out[5]}) begin
            failures++;
            $display("FAIL outputs t=%0d: got %h %h %h %h %h %h want %h %h %h %h %h %h", t,
                     segundos, minutos, horas, dia, mes, anio,
                     exp_out[0], exp_out[1], exp_out[2], exp_out[3], exp_out[4], exp_out[5]);
        end
        checks++;
        if (ad_oe && !control[1]) begin
            failures++;
            $display("FAIL contention: got oe=1 with RD=0 want oe=0");
        end
        if (auto_inc && dato_valido) mem[0] = bcd_inc(mem[0]);
    end

    // ---------------- directed and random stimulus ----------------
    typedef struct packed {
        logic [47:0] regs;
        logic [47:0] want;
    } vec_t;

    vec_t vecs [0:3];

    task automatic load_mem(input logic [47:0] r);
        for (int k = 0; k < 6; k++) mem[k] = r[47 - 8*k -: 8];
    endtask

    task automatic wait_dv(output int n);
        n = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (dato_valido) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_t(input int target);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (t == target) return;
        end
        check("wait_t_timeout", 64'(t), 64'(target));
    endtask

    initial begin
        int n;
        int reads, busy;
        logic [47:0] held;

        vecs[0] = '{regs: 48'h59_59_23_31_12_99, want: 48'h59_59_23_31_12_99};
        vecs[1] = '{regs: 48'h00_00_00_01_01_00, want: 48'h00_00_00_01_01_00};
        vecs[2] = '{regs: 48'h07_45_12_15_06_24, want: 48'h07_45_12_15_06_24};
        vecs[3] = '{regs: 48'hA5_5A_FF_00_81_18, want: 48'hA5_5A_FF_00_81_18};

        repeat (3) @(negedge clk);
        check("reset_bus", {control, ad_oe, ad_out, dato_valido}, {4'b1111, 1'b0, 8'h00, 1'b0});
        check("reset_outputs", {segundos, minutos, horas, dia, mes, anio}, 48'h0);
        reset = 1'b0;
        @(negedge clk);

        // Table: one full sweep per vector, 241-cycle latency each
        for (int v = 0; v < 4; v++) begin
            load_mem(vecs[v].regs);
            habilita = 1'b1;
            wait_dv(n);
            check("latency", 64'(n), 64'd240);
            check("snapshot", {segundos, minutos, horas, dia, mes, anio}, vecs[v].want);
        end

        // Continuous refresh with seconds ticking 00 -> 01
        load_mem(48'h00_30_10_02_03_25);
        @(negedge clk);
        auto_inc = 1'b1;
        wait_dv(n);
        check("cont_latency0", 64'(n), 64'd239);
        check("cont_sec0", 64'(segundos), 64'h00);
        wait_dv(n);
        check("cont_latency1", 64'(n), 64'd240);
        check("cont_sec1", 64'(segundos), 64'h01);
        auto_inc = 1'b0;

        // habilita dropped at idx=2, cnt=10: slot finishes, no publish
        held = {segundos, minutos, horas, dia, mes, anio};
        wait_t(90);
        habilita = 1'b0;
        reads = 0; busy = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (control == 4'b0101) reads++;
            if (i >= 29 && (control != 4'b1111 || ad_oe)) busy++;
            if (dato_valido) check("drop_no_dv", 64'(dato_valido), 64'd0);
        end
        check("drop_read_phase", 64'(reads), 64'd6);
        check("drop_idle_after", 64'(busy), 64'd0);
        check("drop_outputs_held", {segundos, minutos, horas, dia, mes, anio}, held);

        // Reset at idx=4, cnt=28
        load_mem(48'h11_22_13_14_05_16);
        habilita = 1'b1;
        wait_t(188);
        #1 reset = 1'b1;
        #1;
        check("midreset_bus", {control, ad_oe, dato_valido}, {4'b1111, 1'b0, 1'b0});
        check("midreset_outputs", {segundos, minutos, horas, dia, mes, anio}, 48'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_dv(n);
        check("restart_latency", 64'(n), 64'd240);
        check("restart_snapshot", {segundos, minutos, horas, dia, mes, anio}, 48'h11_22_13_14_05_16);

        // Random habilita activity (and rare resets) against the model
        for (int k = 0; k < 6; k++) mem[k] = 8'($urandom_range(0, 255));
        mem[0] = 8'h58;
        auto_inc = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (habilita && $urandom_range(0, 599) == 0) habilita = 1'b0;
            else if (!habilita && $urandom_range(0, 29) == 0) habilita = 1'b1;
            if ($urandom_range(0, 2999) == 0) begin
                #1 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
